// File: rtl/imem_loader.sv
// imem_loader: writes a length-prefixed byte stream into the instruction memory word by word.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   in_valid/in_data      incoming stream byte; in_ready accepts it (state-only)
//   mem_we/addr/data      one-word write port of the instruction memory
//   cpu_hold              holds the core while an image is being loaded
//   done                  one-cycle pulse when the image is complete
//   error                 sticky: header word count larger than the memory
module imem_loader #(
    parameter int unsigned MemSize     = 'h0000_1000,
    parameter bit          HoldAtReset = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       mem_we,
    output logic [$clog2(MemSize)-1:0] mem_addr,
    output logic [31:0]                mem_data,
    output logic                       cpu_hold,
    output logic                       done,
    output logic                       error
);
    localparam int unsigned MemAddrWidth = $clog2(MemSize);
    localparam logic [31:0] Words = 32'(MemSize >> 2);
    typedef enum logic [1:0] {HDR, DATA, DONE, ERR} state_e;
    state_e                    state_q, state_d;
    logic [1:0]                byte_cnt_q, byte_cnt_d;
    logic [MemAddrWidth-3:0]   word_idx_q, word_idx_d;
    logic [31:0]               count_q, count_d;
    logic [23:0]               buf_q, buf_d;
    logic                      mem_we_q, mem_we_d;
    logic [MemAddrWidth-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]               mem_data_q, mem_data_d;
    logic                      hold_q, hold_d;
    logic                      acc;
    logic [31:0]               n_full;
    assign in_ready = (state_q == HDR) || (state_q == DATA);
    assign acc      = in_valid & in_ready;
    assign n_full   = {in_data, count_q[23:0]};
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign cpu_hold = hold_q;
    assign done     = state_q == DONE;
    assign error    = state_q == ERR;
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = acc ? byte_cnt_q + 2'd1 : byte_cnt_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        buf_d      = buf_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        hold_d     = hold_q;
        case (state_q)
            HDR: if (acc) begin
                hold_d = 1'b1;
                count_d[8*byte_cnt_q +: 8] = in_data;
                if (byte_cnt_q == 2'd3) begin
                    word_idx_d = '0;
                    state_d    = n_full == 32'd0 ? DONE : n_full > Words ? ERR : DATA;
                    hold_d     = n_full != 32'd0;
                end
            end
            DATA: if (acc) begin
                // Bytes enter at the top so the first byte lands in [7:0] after three shifts.
                buf_d = {in_data, buf_q[23:8]};
                if (byte_cnt_q == 2'd3) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = {word_idx_q, 2'b00};
                    mem_data_d = {in_data, buf_q};
                    word_idx_d = word_idx_q + 1'b1;
                    if (32'(word_idx_q) == count_q - 32'd1) begin
                        state_d = DONE;
                        hold_d  = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d    = HDR;
                byte_cnt_d = '0;
                word_idx_d = '0;
                count_d    = '0;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HDR;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            buf_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            hold_q     <= HoldAtReset;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            hold_q     <= hold_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; stimulus pushes expected writes/done events, a monitor pops and compares.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    int          total = 0;
    int          bad = 0;
    int          wr_seen = 0;
    logic        prev_we = 1'b0;
    logic [11:0] exp_a_q[$];
    logic [31:0] exp_d_q[$];
    int          done_q[$];
    imem_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .cpu_hold(cpu_hold),
        .done(done), .error(error)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; !in_ready && t < 50; t++) @(negedge clk);
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask
    task automatic send_word(input logic [31:0] w, input int gap);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
    endtask
    task automatic expect_wr(input logic [11:0] a, input logic [31:0] d);
        exp_a_q.push_back(a);
        exp_d_q.push_back(d);
    endtask
    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (mem_we) begin
                if (prev_we) chk("we_one_cycle", 32'd1, 32'd0);
                if (exp_a_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write addr=%h data=%h want=none", mem_addr, mem_data);
                end else begin
                    chk("wr_addr", {20'd0, mem_addr}, {20'd0, exp_a_q.pop_front()});
                    chk("wr_data", mem_data, exp_d_q.pop_front());
                end
                wr_seen++;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done got=1 want=0");
                end else chk("done_writes", wr_seen, done_q.pop_front());
            end
        end
        prev_we = mem_we;
    end
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_outs", {29'd0, mem_we, done, error}, 32'd0);
        chk("rst_addr_data", mem_data | {20'd0, mem_addr}, 32'd0);
        // single word image
        expect_wr(12'h000, 32'h0000_5073);
        done_q.push_back(1);
        send_word(32'd1, 0);
        chk("t1_hold_loading", {31'd0, cpu_hold}, 32'd1);
        send_word(32'h0000_5073, 0);
        chk("t1_we", {31'd0, mem_we}, 32'd1);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_hold_released", {31'd0, cpu_hold}, 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_ready_again", {31'd0, in_ready}, 32'd1);
        // three words with gaps between bytes
        expect_wr(12'h000, 32'h1122_3344);
        expect_wr(12'h004, 32'hDEAD_BEEF);
        expect_wr(12'h008, 32'h00C0_FFEE);
        done_q.push_back(4);
        send_word(32'd3, 1);
        chk("t2_hold", {31'd0, cpu_hold}, 32'd1);
        send_word(32'h1122_3344, 1);
        send_word(32'hDEAD_BEEF, 1);
        send_word(32'h00C0_FFEE, 0);
        chk("t2_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        // empty image
        done_q.push_back(4);
        send_word(32'd0, 0);
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_no_we", {31'd0, mem_we}, 32'd0);
        chk("t3_hold", {31'd0, cpu_hold}, 32'd0);
        @(negedge clk);
        chk("t3_done_pulse", {31'd0, done}, 32'd0);
        // oversize header
        send_word(32'd1025, 0);
        chk("t4_error", {31'd0, error}, 32'd1);
        chk("t4_ready", {31'd0, in_ready}, 32'd0);
        chk("t4_hold", {31'd0, cpu_hold}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (6) @(negedge clk);
        chk("t4_error_sticky", {31'd0, error}, 32'd1);
        chk("t4_ready_sticky", {31'd0, in_ready}, 32'd0);
        do_reset();
        chk("t4_error_cleared", {31'd0, error}, 32'd0);
        chk("t4_ready_after_rst", {31'd0, in_ready}, 32'd1);
        // image filling the whole memory
        for (int i = 0; i < 1024; i++) expect_wr(12'(i * 4), {~16'(i), 16'(i)});
        done_q.push_back(1028);
        send_word(32'd1024, 0);
        chk("t5_no_error", {31'd0, error}, 32'd0);
        for (int i = 0; i < 1024; i++) send_word({~16'(i), 16'(i)}, 0);
        chk("t5_last_addr", {20'd0, mem_addr}, 32'h0000_0FFC);
        chk("t5_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        // reset part way through a word, then a fresh image
        expect_wr(12'h000, 32'hCAFE_F00D);
        send_word(32'd2, 0);
        send_word(32'hCAFE_F00D, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        chk("t6_rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t6_rst_data", mem_data, 32'd0);
        expect_wr(12'h000, 32'h1234_5678);
        done_q.push_back(1030);
        send_word(32'd1, 0);
        send_word(32'h1234_5678, 0);
        chk("t6_done", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
        chk("writes_left", exp_a_q.size(), 32'd0);
        chk("dones_left", done_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
